// File: rtl/coupled_ram_arbiter_pkg.sv
// Shared types for the coupled-RAM arbiter: lock-state enum, read-return tag
// and the round-robin pointer helper.
package coupled_ram_arb_pkg;

    // Tag ids are sized for the largest supported requester count.
    localparam int MAX_REQ = 8;
    localparam int ID_W    = $clog2(MAX_REQ);

    typedef enum logic {
        ARB_UNLOCKED,
        ARB_LOCKED
    } lock_state_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } rd_tag_t;

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g, input int n);
        return (int'(g) == n - 1) ? '0 : g + ID_W'(1);
    endfunction

endpackage

// File: rtl/coupled_ram_arbiter_if.sv
// Requester and RAM-side bus of the coupled-RAM arbiter; suffixes are from
// the arbiter's point of view.
interface coupled_ram_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic [N_REQ-1:0]        req_we_i;
    logic [N_REQ*ADDR_W-1:0] req_addr_i;
    logic [N_REQ*DATA_W-1:0] req_wdata_i;
    logic [N_REQ*BE_W-1:0]   req_be_i;
    logic [N_REQ-1:0]        req_lock_i;
    logic [N_REQ-1:0]        rsp_valid_o;
    logic [DATA_W-1:0]       rsp_rdata_o;
    logic                    ram_en_o;
    logic [BE_W-1:0]         ram_we_o;
    logic [ADDR_W-1:0]       ram_addr_o;
    logic [DATA_W-1:0]       ram_wdata_o;
    logic [DATA_W-1:0]       ram_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, req_lock_i, ram_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, req_lock_i, ram_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
    );

endinterface

// File: rtl/coupled_ram_arbiter_rr_arbiter.sv
// Combinational round-robin grant: lowest requester at or above the pointer,
// falling back to the lowest requester overall when none is above it.
module rr_arbiter
    import coupled_ram_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             valid_o
);

    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] cand;

    always_comb begin
        mask = '0;
        for (int k = 0; k < N_REQ; k++) begin
            mask[k] = (k >= int'(ptr_i));
        end
        cand = (|(req_i & mask)) ? (req_i & mask) : req_i;

        idx_o = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand[k]) begin
                idx_o = ID_W'(k);
            end
        end

        gnt_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            gnt_o[k] = cand[k] && (idx_o == ID_W'(k));
        end
        valid_o = |req_i;
    end

endmodule

// File: rtl/coupled_ram_arbiter.sv
// Shares one single-port coupled RAM between N_REQ requesters with round-robin
// arbitration, bounded burst locking, registered RAM issue and tagged read return.
module coupled_ram_arbiter
    import coupled_ram_arb_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    coupled_ram_arbiter_if.slave bus
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    lock_state_e      state_q, state_d;
    logic [ID_W-1:0]  lock_id_q, lock_id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_REQ-1:0] lock_sel, arb_req, gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             hs, locked;

    logic              sel_we, sel_lock;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [BE_W-1:0]   sel_be;

    logic              en_q, rd_q;
    logic [BE_W-1:0]   we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ID_W-1:0]   id_q;
    rd_tag_t           tag_q [RD_LAT];
    rd_tag_t           tag_out;

    always_comb begin
        lock_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            lock_sel[k] = (ID_W'(k) == lock_id_q);
        end
    end

    // A locked owner that drops valid releases the lock in that same cycle.
    assign locked  = (state_q == ARB_LOCKED) && |(bus.req_valid_i & lock_sel);
    assign arb_req = locked ? (bus.req_valid_i & lock_sel) : bus.req_valid_i;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req_i   (arb_req),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .valid_o (hs)
    );

    assign bus.req_ready_o = gnt;

    always_comb begin
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                sel_we    = bus.req_we_i[k];
                sel_lock  = bus.req_lock_i[k];
                sel_addr  = bus.req_addr_i[k*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata_i[k*DATA_W +: DATA_W];
                sel_be    = bus.req_be_i[k*BE_W +: BE_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        if (!locked) begin
            state_d = ARB_UNLOCKED;
            cnt_d   = '0;
        end
        if (hs) begin
            ptr_d = next_ptr(gnt_idx, N_REQ);
            if (!sel_lock || (locked && int'(cnt_q) + 1 >= MAX_LOCK)) begin
                state_d = ARB_UNLOCKED;
                cnt_d   = '0;
            end else if (locked) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (MAX_LOCK > 1) begin
                state_d   = ARB_LOCKED;
                lock_id_d = gnt_idx;
                cnt_d     = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_UNLOCKED;
            lock_id_q <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
        end
    end

    // Address and data hold their last values between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            rd_q    <= 1'b0;
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            id_q    <= '0;
        end else begin
            en_q <= hs;
            rd_q <= hs && !sel_we;
            we_q <= (hs && sel_we) ? sel_be : '0;
            if (hs) begin
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                id_q    <= gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0].valid <= en_q && rd_q;
            tag_q[0].id    <= id_q;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign tag_out = tag_q[RD_LAT-1];

    always_comb begin
        bus.rsp_valid_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            bus.rsp_valid_o[k] = tag_out.valid && (tag_out.id == ID_W'(k));
        end
    end

    assign bus.rsp_rdata_o = tag_out.valid ? bus.ram_rdata_i : '0;
    assign bus.ram_en_o    = en_q;
    assign bus.ram_we_o    = we_q;
    assign bus.ram_addr_o  = addr_q;
    assign bus.ram_wdata_o = wdata_q;

endmodule

// File: tb/tb_coupled_ram_arbiter.sv
// Directed bench for coupled_ram_arbiter: a 2-requester RD_LAT=1 instance and a
// 3-requester RD_LAT=2 instance, each backed by a small write-first RAM model.
module tb_coupled_ram_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   nChecks = 0;
    int   nFails  = 0;

    always #5 clk = ~clk;

    coupled_ram_arbiter_if #(.N_REQ(2), .ADDR_W(16), .DATA_W(32)) bus2 ();
    coupled_ram_arbiter_if #(.N_REQ(3), .ADDR_W(16), .DATA_W(32)) bus3 ();

    coupled_ram_arbiter #(.N_REQ(2), .ADDR_W(16), .DATA_W(32), .RD_LAT(1), .MAX_LOCK(16)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    coupled_ram_arbiter #(.N_REQ(3), .ADDR_W(16), .DATA_W(32), .RD_LAT(2), .MAX_LOCK(16)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    logic [31:0] mem2 [256];
    logic [31:0] mem3 [256];
    logic [31:0] rd2Q, rd3aQ, rd3bQ;

    always @(posedge clk) begin : ram2Model
        logic [31:0] w;
        if (bus2.ram_en_o) begin
            w = mem2[bus2.ram_addr_o[7:0]];
            for (int b = 0; b < 4; b++) begin
                if (bus2.ram_we_o[b]) w[8*b +: 8] = bus2.ram_wdata_o[8*b +: 8];
            end
            mem2[bus2.ram_addr_o[7:0]] = w;
            rd2Q <= w;
        end
    end

    always @(posedge clk) begin : ram3Model
        logic [31:0] w;
        if (bus3.ram_en_o) begin
            w = mem3[bus3.ram_addr_o[7:0]];
            for (int b = 0; b < 4; b++) begin
                if (bus3.ram_we_o[b]) w[8*b +: 8] = bus3.ram_wdata_o[8*b +: 8];
            end
            mem3[bus3.ram_addr_o[7:0]] = w;
            rd3aQ <= w;
        end
        rd3bQ <= rd3aQ;
    end

    assign bus2.ram_rdata_i = rd2Q;
    assign bus3.ram_rdata_i = rd3bQ;

    task automatic idle2();
        bus2.req_valid_i = '0;
        bus2.req_we_i    = '0;
        bus2.req_addr_i  = '0;
        bus2.req_wdata_i = '0;
        bus2.req_be_i    = '0;
        bus2.req_lock_i  = '0;
    endtask

    task automatic idle3();
        bus3.req_valid_i = '0;
        bus3.req_we_i    = '0;
        bus3.req_addr_i  = '0;
        bus3.req_wdata_i = '0;
        bus3.req_be_i    = '0;
        bus3.req_lock_i  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle2();
        idle3();
        repeat (2) @(negedge clk);
        #1;
        nChecks++; if (bus2.req_ready_o !== 2'b00) begin nFails++; $display("[TB] FAIL reset_ready: got %b expected 00", bus2.req_ready_o); end
        nChecks++; if (bus2.rsp_valid_o !== 2'b00) begin nFails++; $display("[TB] FAIL reset_rsp_valid: got %b expected 00", bus2.rsp_valid_o); end
        nChecks++; if (bus2.rsp_rdata_o !== 32'h0) begin nFails++; $display("[TB] FAIL reset_rsp_rdata: got %h expected 0", bus2.rsp_rdata_o); end
        nChecks++; if (bus2.ram_en_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ram_en: got %b expected 0", bus2.ram_en_o); end
        nChecks++; if (bus2.ram_we_o !== 4'h0) begin nFails++; $display("[TB] FAIL reset_ram_we: got %b expected 0000", bus2.ram_we_o); end
        nChecks++; if (bus2.ram_addr_o !== 16'h0) begin nFails++; $display("[TB] FAIL reset_ram_addr: got %h expected 0", bus2.ram_addr_o); end
        nChecks++; if (bus2.ram_wdata_o !== 32'h0) begin nFails++; $display("[TB] FAIL reset_ram_wdata: got %h expected 0", bus2.ram_wdata_o); end
        nChecks++; if (bus3.ram_en_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ram_en3: got %b expected 0", bus3.ram_en_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [1:0]  expReady, expRsp;
        logic [15:0] expAddr;
        logic [31:0] expData;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus2.req_valid_i = (k < 4) ? 2'b11 : 2'b00;
            bus2.req_we_i    = 2'b00;
            bus2.req_addr_i  = {16'h0020, 16'h0010};
            #1;
            expReady = (k >= 4) ? 2'b00 : ((k % 2 == 1) ? 2'b10 : 2'b01);
            nChecks++; if (bus2.req_ready_o !== expReady) begin nFails++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", k, bus2.req_ready_o, expReady); end
            if (k >= 1 && k <= 4) begin
                expAddr = ((k - 1) % 2 == 1) ? 16'h0020 : 16'h0010;
                nChecks++; if (bus2.ram_en_o !== 1'b1) begin nFails++; $display("[TB] FAIL rr_ram_en[%0d]: got %b expected 1", k, bus2.ram_en_o); end
                nChecks++; if (bus2.ram_addr_o !== expAddr) begin nFails++; $display("[TB] FAIL rr_ram_addr[%0d]: got %h expected %h", k, bus2.ram_addr_o, expAddr); end
                nChecks++; if (bus2.ram_we_o !== 4'h0) begin nFails++; $display("[TB] FAIL rr_ram_we[%0d]: got %b expected 0000", k, bus2.ram_we_o); end
            end
            if (k >= 2) begin
                expRsp  = ((k - 2) % 2 == 1) ? 2'b10 : 2'b01;
                expData = ((k - 2) % 2 == 1) ? 32'hC0DE_0020 : 32'hC0DE_0010;
                nChecks++; if (bus2.rsp_valid_o !== expRsp) begin nFails++; $display("[TB] FAIL rr_rsp_valid[%0d]: got %b expected %b", k, bus2.rsp_valid_o, expRsp); end
                nChecks++; if (bus2.rsp_rdata_o !== expData) begin nFails++; $display("[TB] FAIL rr_rsp_rdata[%0d]: got %h expected %h", k, bus2.rsp_rdata_o, expData); end
            end
        end
    endtask

    task automatic test_write_merge();
        @(negedge clk);
        bus2.req_valid_i = 2'b10;
        bus2.req_we_i    = 2'b10;
        bus2.req_addr_i  = {16'h0040, 16'h0000};
        bus2.req_wdata_i = {32'hDEAD_BEEF, 32'h0};
        bus2.req_be_i    = {4'b0011, 4'b0000};
        #1;
        nChecks++; if (bus2.req_ready_o !== 2'b10) begin nFails++; $display("[TB] FAIL wr_ready: got %b expected 10", bus2.req_ready_o); end
        @(negedge clk);
        bus2.req_we_i = 2'b00;
        #1;
        nChecks++; if (bus2.req_ready_o !== 2'b10) begin nFails++; $display("[TB] FAIL rd_after_wr_ready: got %b expected 10", bus2.req_ready_o); end
        nChecks++; if (bus2.ram_we_o !== 4'b0011) begin nFails++; $display("[TB] FAIL wr_ram_we: got %b expected 0011", bus2.ram_we_o); end
        nChecks++; if (bus2.ram_addr_o !== 16'h0040) begin nFails++; $display("[TB] FAIL wr_ram_addr: got %h expected 0040", bus2.ram_addr_o); end
        nChecks++; if (bus2.ram_wdata_o !== 32'hDEAD_BEEF) begin nFails++; $display("[TB] FAIL wr_ram_wdata: got %h expected deadbeef", bus2.ram_wdata_o); end
        @(negedge clk);
        idle2();
        #1;
        nChecks++; if (bus2.ram_en_o !== 1'b1) begin nFails++; $display("[TB] FAIL rd_ram_en: got %b expected 1", bus2.ram_en_o); end
        nChecks++; if (bus2.ram_we_o !== 4'b0000) begin nFails++; $display("[TB] FAIL rd_ram_we: got %b expected 0000", bus2.ram_we_o); end
        nChecks++; if (bus2.rsp_valid_o !== 2'b00) begin nFails++; $display("[TB] FAIL wr_no_rsp: got %b expected 00", bus2.rsp_valid_o); end
        @(negedge clk);
        #1;
        nChecks++; if (bus2.rsp_valid_o !== 2'b10) begin nFails++; $display("[TB] FAIL merge_rsp_valid: got %b expected 10", bus2.rsp_valid_o); end
        nChecks++; if (bus2.rsp_rdata_o !== 32'h0000_BEEF) begin nFails++; $display("[TB] FAIL merge_rsp_rdata: got %h expected 0000beef", bus2.rsp_rdata_o); end
        nChecks++; if (bus2.ram_en_o !== 1'b0) begin nFails++; $display("[TB] FAIL merge_ram_idle: got %b expected 0", bus2.ram_en_o); end
    endtask

    task automatic test_lock_max();
        logic [1:0] expReady;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus2.req_valid_i = 2'b11;
            bus2.req_lock_i  = 2'b01;
            bus2.req_addr_i  = {16'h0021, 16'h0011};
            #1;
            expReady = (k == 16) ? 2'b10 : 2'b01;
            nChecks++; if (bus2.req_ready_o !== expReady) begin nFails++; $display("[TB] FAIL lock_max_ready[%0d]: got %b expected %b", k, bus2.req_ready_o, expReady); end
        end
        @(negedge clk);
        idle2();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lock_drop();
        logic [1:0] vecValid [5];
        logic [1:0] vecReady [5];
        vecValid = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b00};
        vecReady = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b00};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus2.req_valid_i = vecValid[k];
            bus2.req_lock_i  = 2'b01;
            #1;
            nChecks++; if (bus2.req_ready_o !== vecReady[k]) begin nFails++; $display("[TB] FAIL lock_drop_ready[%0d]: got %b expected %b", k, bus2.req_ready_o, vecReady[k]); end
        end
        idle2();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        bus3.req_valid_i = 3'b100;
        bus3.req_addr_i  = {16'h0030, 16'h0000, 16'h0000};
        #1;
        nChecks++; if (bus3.req_ready_o !== 3'b100) begin nFails++; $display("[TB] FAIL mid_ready: got %b expected 100", bus3.req_ready_o); end
        @(negedge clk);
        idle3();
        #1;
        nChecks++; if (bus3.ram_en_o !== 1'b1) begin nFails++; $display("[TB] FAIL mid_ram_en: got %b expected 1", bus3.ram_en_o); end
        rst_n = 1'b0;
        #1;
        nChecks++; if (bus3.ram_en_o !== 1'b0) begin nFails++; $display("[TB] FAIL mid_rst_ram_en: got %b expected 0", bus3.ram_en_o); end
        nChecks++; if (bus3.ram_addr_o !== 16'h0) begin nFails++; $display("[TB] FAIL mid_rst_ram_addr: got %h expected 0", bus3.ram_addr_o); end
        nChecks++; if (bus3.rsp_valid_o !== 3'b000) begin nFails++; $display("[TB] FAIL mid_rst_rsp: got %b expected 000", bus3.rsp_valid_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            nChecks++; if (bus3.rsp_valid_o !== 3'b000) begin nFails++; $display("[TB] FAIL post_rst_rsp[%0d]: got %b expected 000", k, bus3.rsp_valid_o); end
        end
        @(negedge clk);
        bus3.req_valid_i = 3'b001;
        bus3.req_addr_i  = {16'h0000, 16'h0000, 16'h0031};
        #1;
        nChecks++; if (bus3.req_ready_o !== 3'b001) begin nFails++; $display("[TB] FAIL post_rst_ready: got %b expected 001", bus3.req_ready_o); end
        @(negedge clk);
        idle3();
        #1;
        nChecks++; if (bus3.ram_addr_o !== 16'h0031) begin nFails++; $display("[TB] FAIL post_rst_ram_addr: got %h expected 0031", bus3.ram_addr_o); end
        @(negedge clk);
        #1;
        nChecks++; if (bus3.rsp_valid_o !== 3'b000) begin nFails++; $display("[TB] FAIL post_rst_early_rsp: got %b expected 000", bus3.rsp_valid_o); end
        @(negedge clk);
        #1;
        nChecks++; if (bus3.rsp_valid_o !== 3'b001) begin nFails++; $display("[TB] FAIL post_rst_rsp_valid: got %b expected 001", bus3.rsp_valid_o); end
        nChecks++; if (bus3.rsp_rdata_o !== 32'h3000_0031) begin nFails++; $display("[TB] FAIL post_rst_rsp_rdata: got %h expected 30000031", bus3.rsp_rdata_o); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [2:0]  expReady, expRsp;
        logic        expEn;
        logic [31:0] expData;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            a = 16'h0050 + 16'(k);
            bus3.req_valid_i = (k < 8) ? 3'b100 : 3'b000;
            bus3.req_addr_i  = {a, 16'h0000, 16'h0000};
            #1;
            expReady = (k < 8) ? 3'b100 : 3'b000;
            nChecks++; if (bus3.req_ready_o !== expReady) begin nFails++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected %b", k, bus3.req_ready_o, expReady); end
            expEn = (k >= 1 && k <= 8);
            nChecks++; if (bus3.ram_en_o !== expEn) begin nFails++; $display("[TB] FAIL b2b_ram_en[%0d]: got %b expected %b", k, bus3.ram_en_o, expEn); end
            expRsp = (k >= 3 && k <= 10) ? 3'b100 : 3'b000;
            nChecks++; if (bus3.rsp_valid_o !== expRsp) begin nFails++; $display("[TB] FAIL b2b_rsp_valid[%0d]: got %b expected %b", k, bus3.rsp_valid_o, expRsp); end
            if (k >= 3 && k <= 10) begin
                expData = 32'h3000_0050 + 32'(k - 3);
                nChecks++; if (bus3.rsp_rdata_o !== expData) begin nFails++; $display("[TB] FAIL b2b_rsp_rdata[%0d]: got %h expected %h", k, bus3.rsp_rdata_o, expData); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem2[i] = 32'hC0DE_0000 | 32'(i);
            mem3[i] = 32'h3000_0000 | 32'(i);
        end
        mem2[8'h40] = 32'h0;
        rd2Q  = '0;
        rd3aQ = '0;
        rd3bQ = '0;
        test_reset();
        test_round_robin();
        test_write_merge();
        test_lock_max();
        test_lock_drop();
        test_reset_midflight();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
